odd_seq_checker: RTL and testbench
==================================

// Module: odd_seq_checker
// PURPOSE
//   Receiving-end monitor for the 4-bit odd-sequence counter (0 -> 1 -> 3 -> ... -> 15 -> 1 ...).
//   It samples the counter output on each strobe and predicts the next value.
//   It acquires lock after a run of correct transitions and flags every deviation.
//   It keeps a saturating error count and pulses once per 15 -> 1 wrap.
//   It sits beside the counter on the same clock, as a bring-up and self-check block.
// PARAMETERS
//   LOCK_N  3  consecutive matching samples needed to enter LOCK; legal range 1..15.
//   ERR_W   8  width of err_cnt.
//   RELOCK  1  1: FAULT re-acquires on the next legal sample. 0: FAULT holds until reset.
// PORTS
//   clk        in   1      rising-edge clock, shared with the counter.
//   clr        in   1      asynchronous active-low reset.
//   sample_en  in   1      q_in is sampled on clk edges where this is 1.
//   q_in       in   4      counter value under test.
//   locked     out  1      1 while state == LOCK.
//   err_pulse  out  1      one-cycle pulse per mismatching or illegal sample.
//   wrap_pulse out  1      one-cycle pulse when a matched 15 is sampled in LOCK.
//   err_cnt    out  ERR_W  saturating error count.
//   expected   out  4      predicted value of the next sample.
//   state      out  2      0 = IDLE, 1 = ACQ, 2 = LOCK, 3 = FAULT.
// BEHAVIOUR
//   - Reset (clr = 0, async): state = IDLE, expected = 0, good_cnt = 0, err_cnt = 0.
//     All 1-bit outputs are 0. Reset takes effect immediately, including mid-sequence.
//   - nxt(v): 1 if v == 0 or v == 15, otherwise v + 2.
//     legal(v): v == 0 or v is odd.
//   - All outputs are registered. Each pulse is high for the single cycle after the sampling edge.
//   - When sample_en = 0: state, expected, good_cnt and err_cnt hold; err_pulse = wrap_pulse = 0.
//   - IDLE, on a sample:
//       legal(q_in) -> expected = nxt(q_in), good_cnt = 0, go to ACQ.
//       otherwise   -> err_pulse, stay in IDLE.
//   - ACQ, on a sample:
//       q_in == expected -> good_cnt++, expected = nxt(q_in).
//                           Go to LOCK when good_cnt reaches LOCK_N (locked = 1 next cycle).
//       mismatch         -> err_pulse, then re-seed:
//                           if legal(q_in): expected = nxt(q_in), good_cnt = 0, stay in ACQ.
//                           else: go to IDLE.
//   - LOCK, on a sample:
//       q_in == expected -> expected = nxt(q_in), stay in LOCK.
//                           If q_in == 15, also wrap_pulse.
//       mismatch         -> err_pulse, locked = 0, go to FAULT; expected holds.
//                           A value of 0 in LOCK is a mismatch.
//   - FAULT, on a sample:
//       RELOCK = 1 and legal(q_in) -> expected = nxt(q_in), good_cnt = 0, go to ACQ.
//       otherwise                  -> stay in FAULT. Each further mismatch raises err_pulse.
//   - err_cnt increments on every err_pulse and saturates at 2^ERR_W - 1 (no wrap).
//   - good_cnt width is 4 bits; it never exceeds LOCK_N.
//   - A matched 15 -> 1 transition counts as a good transition in ACQ.
//   - No latency beyond one register stage.
// TESTING
//   T1 Reset, then feed 0,1,3,5,7 with sample_en = 1 every cycle, LOCK_N = 3:
//      state IDLE -> ACQ -> ACQ -> ACQ -> LOCK; locked = 1 after the 4th sample; err_cnt = 0.
//   T2 Locked stream ...13,15,1,3:
//      wrap_pulse exactly once (the cycle after 15 is sampled); expected goes 15 -> 1 -> 3 -> 5.
//   T3 Locked, inject 6 in place of 7:
//      err_pulse once, locked = 0, state = FAULT, err_cnt = 1.
//      Next sample 9 -> state = ACQ, expected = 11.
//   T4 Locked, inject 0 in place of 9:
//      state = FAULT, err_cnt += 1.
//      With RELOCK = 0, the following samples 11, 13 leave the state at FAULT.
//   T5 ERR_W = 2, feed 2,4,6,8,10 in IDLE:
//      err_pulse on every sample; err_cnt = 1, 2, 3, 3, 3 (saturates).
//   T6 Assert clr mid-stream with sample_en toggling:
//      all outputs return to reset values asynchronously.
//      Gaps with sample_en = 0 never change expected or err_cnt.

Source files
------------

// File: rtl/odd_seq_checker.sv
// Receive-side monitor for the 4-bit odd-sequence counter (0,1,3,...,15,1,...).
// Predicts each strobed sample, locks after a run of matches, counts errors.
module odd_seq_checker #(
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8,
  parameter bit RELOCK = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sample_en,
  input  logic [3:0]       q_in,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       expected,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    LOCK  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [3:0]       LOCK_N_V = 4'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_expected, w_expected_nxt;
  logic [3:0]       r_good_cnt, w_good_cnt_nxt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_locked, r_err_pulse, r_wrap_pulse;
  logic             w_err, w_wrap, w_legal, w_match;
  logic [3:0]       w_nxt;

  function automatic logic [3:0] nxt_val(input logic [3:0] v);
    return (v == 4'd0 || v == 4'd15) ? 4'd1 : v + 4'd2;
  endfunction

  assign w_nxt   = nxt_val(q_in);
  assign w_legal = (q_in == 4'd0) || q_in[0];
  assign w_match = (q_in == r_expected);

  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_good_cnt_nxt = r_good_cnt;
    w_err          = 1'b0;
    w_wrap         = 1'b0;
    if (sample_en) begin
      unique case (r_state)
        IDLE: begin
          if (w_legal) begin
            w_expected_nxt = w_nxt;
            w_good_cnt_nxt = 4'd0;
            w_state_nxt    = ACQ;
          end else begin
            w_err = 1'b1;
          end
        end
        ACQ: begin
          if (w_match) begin
            w_good_cnt_nxt = r_good_cnt + 4'd1;
            w_expected_nxt = w_nxt;
            if (r_good_cnt + 4'd1 == LOCK_N_V) w_state_nxt = LOCK;
          end else begin
            w_err          = 1'b1;
            w_good_cnt_nxt = 4'd0;
            if (w_legal) w_expected_nxt = w_nxt;
            else         w_state_nxt    = IDLE;
          end
        end
        LOCK: begin
          // A 0 never equals a prediction made in LOCK, so it lands here as a mismatch.
          if (w_match) begin
            w_expected_nxt = w_nxt;
            w_wrap         = (q_in == 4'd15);
          end else begin
            w_err       = 1'b1;
            w_state_nxt = FAULT;
          end
        end
        FAULT: begin
          if (RELOCK && w_legal) begin
            w_expected_nxt = w_nxt;
            w_good_cnt_nxt = 4'd0;
            w_state_nxt    = ACQ;
          end else if (!w_match) begin
            w_err = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state      <= IDLE;
      r_expected   <= 4'd0;
      r_good_cnt   <= 4'd0;
      r_err_cnt    <= '0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_expected   <= w_expected_nxt;
      r_good_cnt   <= w_good_cnt_nxt;
      r_locked     <= (w_state_nxt == LOCK);
      r_err_pulse  <= w_err;
      r_wrap_pulse <= w_wrap;
      if (w_err && r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign locked     = r_locked;
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign err_cnt    = r_err_cnt;
  assign expected   = r_expected;
  assign state      = r_state;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Scoreboard bench for odd_seq_checker: two instances (relocking / sticky-fault,
// wide / 2-bit error counter) fed the same directed and random sample stream.
module tb_odd_seq_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, sample_en;
  logic [3:0] q_in;

  logic       a_locked, a_err, a_wrap;
  logic [7:0] a_ec;
  logic [3:0] a_exp;
  logic [1:0] a_st;
  logic       b_locked, b_err, b_wrap;
  logic [1:0] b_ec;
  logic [3:0] b_exp;
  logic [1:0] b_st;

  odd_seq_checker #(.LOCK_N(3), .ERR_W(8), .RELOCK(1'b1)) dut_a (
    .clk(clk), .clr(clr), .sample_en(sample_en), .q_in(q_in),
    .locked(a_locked), .err_pulse(a_err), .wrap_pulse(a_wrap),
    .err_cnt(a_ec), .expected(a_exp), .state(a_st));

  odd_seq_checker #(.LOCK_N(2), .ERR_W(2), .RELOCK(1'b0)) dut_b (
    .clk(clk), .clr(clr), .sample_en(sample_en), .q_in(q_in),
    .locked(b_locked), .err_pulse(b_err), .wrap_pulse(b_wrap),
    .err_cnt(b_ec), .expected(b_exp), .state(b_st));

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] ex;
    logic       lk;
    logic       ep;
    logic       wp;
    logic [7:0] ec;
  } exp_t;

  localparam int S_IDLE = 0, S_ACQ = 1, S_LOCK = 2, S_FAULT = 3;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int m_st[2], m_exp[2], m_gc[2], m_ec[2];

  function automatic int nxt(int v);
    return (v == 0 || v == 15) ? 1 : v + 2;
  endfunction

  function automatic bit legal(int v);
    return (v == 0) || (v % 2 == 1);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE; m_exp[i] = 0; m_gc[i] = 0; m_ec[i] = 0;
    end
  endfunction

  function automatic exp_t model_step(int i, bit en, int q);
    exp_t e;
    bit   err = 1'b0;
    bit   wrap = 1'b0;
    int   lockn = (i == 0) ? 3 : 2;
    int   emax = (i == 0) ? 255 : 3;
    bit   relock = (i == 0);
    if (en) begin
      case (m_st[i])
        S_IDLE:
          if (legal(q)) begin m_exp[i] = nxt(q); m_gc[i] = 0; m_st[i] = S_ACQ; end
          else err = 1'b1;
        S_ACQ:
          if (q == m_exp[i]) begin
            m_gc[i]++; m_exp[i] = nxt(q);
            if (m_gc[i] == lockn) m_st[i] = S_LOCK;
          end else begin
            err = 1'b1; m_gc[i] = 0;
            if (legal(q)) m_exp[i] = nxt(q);
            else m_st[i] = S_IDLE;
          end
        S_LOCK:
          if (q == m_exp[i]) begin wrap = (q == 15); m_exp[i] = nxt(q); end
          else begin err = 1'b1; m_st[i] = S_FAULT; end
        default:
          if (relock && legal(q)) begin m_exp[i] = nxt(q); m_gc[i] = 0; m_st[i] = S_ACQ; end
          else if (q != m_exp[i]) err = 1'b1;
      endcase
      if (err && m_ec[i] < emax) m_ec[i]++;
    end
    e.st = 2'(m_st[i]);
    e.ex = 4'(m_exp[i]);
    e.lk = (m_st[i] == S_LOCK);
    e.ep = err;
    e.wp = wrap;
    e.ec = 8'(m_ec[i]);
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic cmp(string tag, exp_t e, logic [1:0] st, logic [3:0] ex,
                     logic lk, logic ep, logic wp, logic [7:0] ec);
    chk({tag, "_state"},      32'(st), 32'(e.st));
    chk({tag, "_expected"},   32'(ex), 32'(e.ex));
    chk({tag, "_locked"},     32'(lk), 32'(e.lk));
    chk({tag, "_err_pulse"},  32'(ep), 32'(e.ep));
    chk({tag, "_wrap_pulse"}, 32'(wp), 32'(e.wp));
    chk({tag, "_err_cnt"},    32'(ec), 32'(e.ec));
  endtask

  task automatic check_reset_now(string tag);
    cmp({tag, "_a"}, '0, a_st, a_exp, a_locked, a_err, a_wrap, a_ec);
    cmp({tag, "_b"}, '0, b_st, b_exp, b_locked, b_err, b_wrap, {6'd0, b_ec});
  endtask

  task automatic send(bit en, logic [3:0] q);
    @(negedge clk);
    clr = 1'b1;
    sample_en = en;
    q_in = q;
    sb_a.push_back(model_step(0, en, int'(q)));
    sb_b.push_back(model_step(1, en, int'(q)));
  endtask

  // Reset lands between clock edges so its asynchronous effect is visible at once.
  task automatic rst_pulse();
    @(negedge clk);
    sample_en = 1'($urandom);
    q_in = 4'($urandom);
    model_reset();
    sb_a.push_back('0);
    sb_b.push_back('0);
    #2 clr = 1'b0;
    #1 check_reset_now("async_rst");
    @(negedge clk);
    sample_en = 1'($urandom);
    q_in = 4'($urandom);
    sb_a.push_back('0);
    sb_b.push_back('0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        cmp("a", e, a_st, a_exp, a_locked, a_err, a_wrap, a_ec);
      end
      if (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        cmp("b", e, b_st, b_exp, b_locked, b_err, b_wrap, {6'd0, b_ec});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t1[24] = '{0, 1, 3, 5, 7, 9, 11, 13, 15, 1, 3, 5,
                     6, 9, 11, 13, 15, 1, 3, 5, 7, 0, 11, 13};
    int   t5[5] = '{2, 4, 6, 8, 10};
    int   r;
    logic [3:0] src;

    clr = 1'b0;
    sample_en = 1'b0;
    q_in = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_now("init_rst");

    foreach (t1[i]) send(1'b1, 4'(t1[i]));
    send(1'b0, 4'd9);
    send(1'b0, 4'd2);
    send(1'b1, 4'd15);

    rst_pulse();
    foreach (t5[i]) send(1'b1, 4'(t5[i]));
    send(1'b0, 4'd12);

    rst_pulse();
    src = 4'd0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        rst_pulse();
        src = 4'd0;
      end else if (r < 25) begin
        send(1'b0, 4'($urandom));
      end else if (r < 33) begin
        send(1'b1, 4'($urandom));
      end else begin
        send(1'b1, src);
        src = 4'(nxt(int'(src)));
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_drain_a", 32'(sb_a.size()), 32'd0);
    chk("sb_drain_b", 32'(sb_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
